instr_stream_sequencer: RTL and testbench
=========================================

# instr_stream_sequencer

Program memory plus streaming engine that produces the experiment FSM's instruction AXI-Stream and its `halt` flag. The CPU loads a program of instruction words, sets a length and repeat count, then pulses `start`. The block replays the program as a gap-free AXIS stream, honouring `tready`. It raises `halt` once the last word has been accepted, so the consumer stops cleanly on stream empty.

## Interface

**Parameters**
- `INSTR_W`, 17: instruction word width; matches the consumer's instruction bus.
- `DEPTH`, 1024: program memory depth in words; power of two.
- `AW`, `$clog2(DEPTH)`: address width.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `prog_wr_en` in 1: program memory write strobe from the CPU.
- `prog_wr_addr` in AW: write address.
- `prog_wr_data` in INSTR_W: write data.
- `prog_len` in AW+1: words per pass; legal range 1..DEPTH.
- `loop_cnt` in 16: number of passes; a value of 0 is treated as 1.
- `start` in 1: rising-edge start request.
- `abort` in 1: level; stop streaming immediately.
- `m_axis_tdata` out INSTR_W: instruction word.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready from the consumer.
- `halt` out 1: high means no further words will follow.
- `busy` out 1: high from the accepted start until the state returns to IDLE.
- `pass_idx` out 16: index of the current pass, counting from 0.
- `err` out 1: sticky error flag.

## Operation

**Program memory**
- Single-clock, synchronous-read RAM of DEPTH × INSTR_W.
- CPU writes are accepted only while `busy`=0.
- A write while `busy`=1 is dropped and sets `err`.

**State machine: IDLE → PRIME → STREAM → DONE → IDLE**
- **IDLE**
  - `halt`=1, `busy`=0.
  - A rising edge on `start` with `prog_len` in 1..DEPTH does all of the following:
    - latches `prog_len` and `loop_cnt`;
    - clears `pass_idx`, the read address, and `err`;
    - goes to PRIME.
  - A `start` edge with an illegal `prog_len` sets `err` and the block stays in IDLE.
- **PRIME**
  - One cycle: issues the RAM read of address 0.
  - Deasserts `halt` and asserts `busy`.
- **STREAM**
  - A 2-entry output skid buffer is fed by the RAM read pipeline.
  - A read is issued whenever (free slots − reads in flight) > 0 and words remain.
  - The read address wraps to 0 at `prog_len`−1. On each wrap:
    - `pass_idx` increments;
    - when `pass_idx` = latched `loop_cnt`−1, no further reads are issued.
  - When the last word of the last pass is handshaken (`tvalid`&`tready`), the next state is DONE.
- **DONE**
  - `halt`=1, `tvalid`=0.
  - Waits for `start` to be low, then goes to IDLE, where `busy` drops.
- **abort** (in PRIME or STREAM)
  - On the next edge: `tvalid`=0, skid buffer flushed, in-flight read discarded, `halt`=1, state = DONE.
  - An abort arriving in the same cycle as a final handshake is still treated as the abort; the final word counts as delivered.

**Reset values**
- `m_axis_tdata`=0, `m_axis_tvalid`=0, `halt`=1, `busy`=0, `pass_idx`=0, `err`=0.
- State = IDLE. RAM contents are not reset.
- Reset asserted mid-stream returns the block to these values asynchronously.

## Timing

- `start` edge sampled at cycle 0:
  - PRIME at cycle 1;
  - first `tvalid`=1 at cycle 3.
- Throughput: with `tready` held high, exactly one word per cycle, with no bubbles across pass wraps.
- AXIS rules:
  - `tdata` is stable while `tvalid`=1 and `tready`=0;
  - `tvalid` never drops without a handshake, except on abort or reset.
- `halt` rises in the cycle after the final handshake, in the same edge that drops `tvalid`.
  - The consumer therefore never sees `tvalid`=0 with `halt`=1 before the stream has ended.
- Total words per run = `prog_len` × max(`loop_cnt`, 1).

## Configuration

- `SEQ_LOOP_EN` defined:
  - `loop_cnt` is honoured as described;
  - `pass_idx` counts passes.
- `SEQ_LOOP_EN` undefined:
  - `loop_cnt` is ignored and every run is exactly one pass;
  - `pass_idx` is tied to 0 and the pass counter logic is removed.

## Test plan

- Load words 0x0001..0x0005, `prog_len`=5, `loop_cnt`=1, `tready`=1.
  - Expect 0x0001..0x0005 on consecutive cycles, first word at cycle 3.
  - Expect `halt`=1 on the cycle after 0x0005 is accepted.
- Same program with `tready` toggling 1,0,0,1 repeatedly.
  - Expect the same 5-word sequence with no loss or duplication, and `tdata` stable while stalled.
- `prog_len`=3, `loop_cnt`=4 (`SEQ_LOOP_EN` defined).
  - Expect 12 words repeating A,B,C, `pass_idx` stepping 0→3, and no bubbles at wraps.
- Assert `abort` after the 2nd handshake of a 5-word program.
  - Expect `tvalid`=0 and `halt`=1 on the next cycle, then DONE, then IDLE once `start` is low.
- Start with `prog_len`=0.
  - Expect `err`=1, stay in IDLE, `tvalid` never asserted.
- Write the program while `busy`=1.
  - Expect the RAM contents unchanged and `err`=1.

Source files
------------

// File: rtl/instr_stream_sequencer.sv
// Program RAM plus AXI-Stream replay engine for the experiment FSM's instruction stream.
// Define SEQ_LOOP_EN to honour loop_cnt (multi-pass replay); otherwise every run is one pass.
module instr_stream_sequencer #(
    parameter int INSTR_W = 17,
    parameter int DEPTH   = 1024,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_wr_en,
    input  logic [AW-1:0]      prog_wr_addr,
    input  logic [INSTR_W-1:0] prog_wr_data,
    input  logic [AW:0]        prog_len,
    input  logic [15:0]        loop_cnt,
    input  logic               start,
    input  logic               abort,
    output logic [INSTR_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               halt,
    output logic               busy,
    output logic [15:0]        pass_idx,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_r, state_s;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] rd_data_r;
    logic               rd_vld_r;
    logic [AW-1:0]      rd_addr_r;
    logic [AW:0]        len_r;
    logic               reads_done_r;
    logic               start_d_r;
    logic               out_vld_r, sk_vld_r;
    logic [INSTR_W-1:0] out_data_r, sk_data_r;
    logic               halt_r, busy_r, err_r;

    logic               start_rise_s, len_ok_s, load_s, pop_s, last_pop_s;
    logic               wrap_s, last_pass_s, credit_s, rd_en_s, flush_s, active_s;
    logic [1:0]         occ_s;

    assign start_rise_s = start & ~start_d_r;
    assign len_ok_s     = (prog_len != {(AW+1){1'b0}}) && (prog_len <= (AW+1)'(DEPTH));
    assign load_s       = (state_r == IDLE) & start_rise_s & len_ok_s;
    assign active_s     = (state_r == PRIME) | (state_r == STREAM);
    assign flush_s      = active_s & abort;
    assign pop_s        = out_vld_r & m_axis_tready;
    // Last word: nothing queued behind the output register and no reads left to issue.
    assign last_pop_s   = pop_s & ~sk_vld_r & ~rd_vld_r & reads_done_r;
    assign wrap_s       = ({1'b0, rd_addr_r} == (len_r - {{AW{1'b0}}, 1'b1}));
    // Occupancy after this cycle counting the word landing from the RAM; a new read
    // is safe only if a slot is still free when it lands even if nothing pops then.
    assign occ_s        = {1'b0, out_vld_r} + {1'b0, sk_vld_r} + {1'b0, rd_vld_r} - {1'b0, pop_s};
    assign credit_s     = (occ_s < 2'd2);
    assign rd_en_s      = ~abort & ((state_r == PRIME) |
                                    ((state_r == STREAM) & ~reads_done_r & credit_s));

`ifdef SEQ_LOOP_EN
    logic [15:0] pass_r, loops_r;

    // Pass counter: steps on every read-address wrap except the final one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_r  <= 16'd0;
            loops_r <= 16'd1;
        end else if (load_s) begin
            pass_r  <= 16'd0;
            loops_r <= (loop_cnt == 16'd0) ? 16'd1 : loop_cnt;
        end else if (rd_en_s && wrap_s && !last_pass_s) begin
            pass_r  <= pass_r + 16'd1;
        end
    end

    assign last_pass_s = (pass_r == (loops_r - 16'd1));
    assign pass_idx    = pass_r;
`else
    logic loop_cnt_unused_s;
    assign loop_cnt_unused_s = ^loop_cnt;
    assign last_pass_s       = 1'b1;
    assign pass_idx          = 16'd0;
`endif

    // Program RAM: CPU write port (blocked while busy) and synchronous read port.
    always_ff @(posedge clk) begin
        if (prog_wr_en && !busy_r) begin
            mem[prog_wr_addr] <= prog_wr_data;
        end
        if (rd_en_s) begin
            rd_data_r <= mem[rd_addr_r];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_s) state_s = PRIME;
                else        state_s = IDLE;
            end
            PRIME: begin
                if (abort) state_s = DONE;
                else       state_s = STREAM;
            end
            STREAM: begin
                if (abort || last_pop_s) state_s = DONE;
                else                     state_s = STREAM;
            end
            DONE: begin
                if (!start) state_s = IDLE;
                else        state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Read sequencing, skid buffer and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_d_r    <= 1'b0;
            len_r        <= {(AW+1){1'b0}};
            rd_addr_r    <= {AW{1'b0}};
            reads_done_r <= 1'b0;
            rd_vld_r     <= 1'b0;
            out_vld_r    <= 1'b0;
            out_data_r   <= {INSTR_W{1'b0}};
            sk_vld_r     <= 1'b0;
            sk_data_r    <= {INSTR_W{1'b0}};
            halt_r       <= 1'b1;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            start_d_r <= start;

            if (load_s) begin
                len_r        <= prog_len;
                rd_addr_r    <= {AW{1'b0}};
                reads_done_r <= 1'b0;
            end else if (rd_en_s) begin
                if (wrap_s) begin
                    rd_addr_r    <= {AW{1'b0}};
                    reads_done_r <= last_pass_s;
                end else begin
                    rd_addr_r    <= rd_addr_r + {{(AW-1){1'b0}}, 1'b1};
                end
            end

            rd_vld_r <= rd_en_s;

            if (flush_s) begin
                out_vld_r <= 1'b0;
                sk_vld_r  <= 1'b0;
            end else if (!out_vld_r || pop_s) begin
                if (sk_vld_r) begin
                    out_data_r <= sk_data_r;
                    sk_vld_r   <= rd_vld_r;
                    sk_data_r  <= rd_data_r;
                end else begin
                    out_vld_r  <= rd_vld_r;
                    if (rd_vld_r) out_data_r <= rd_data_r;
                end
            end else if (rd_vld_r) begin
                sk_vld_r  <= 1'b1;
                sk_data_r <= rd_data_r;
            end

            halt_r <= !((state_s == PRIME) || (state_s == STREAM));
            busy_r <= (state_s != IDLE);

            if (prog_wr_en && busy_r) begin
                err_r <= 1'b1;
            end else if ((state_r == IDLE) && start_rise_s) begin
                err_r <= ~len_ok_s;
            end
        end
    end

    assign m_axis_tdata  = out_data_r;
    assign m_axis_tvalid = out_vld_r;
    assign halt          = halt_r;
    assign busy          = busy_r;
    assign err           = err_r;

endmodule

// File: tb/tb_instr_stream_sequencer.sv
// Directed bench for instr_stream_sequencer: replay, stalls, loops, abort and error cases.
module tb_instr_stream_sequencer;

    localparam int INSTR_W = 17;
    localparam int DEPTH   = 1024;
    localparam int AW      = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               prog_wr_en;
    logic [AW-1:0]      prog_wr_addr;
    logic [INSTR_W-1:0] prog_wr_data;
    logic [AW:0]        prog_len;
    logic [15:0]        loop_cnt;
    logic               start;
    logic               abort;
    logic [INSTR_W-1:0] m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               halt;
    logic               busy;
    logic [15:0]        pass_idx;
    logic               err;

    int checks = 0;
    int errors = 0;
    logic [INSTR_W-1:0] model [DEPTH];
    logic [3:0]         rdy_pat = 4'b1001;

    instr_stream_sequencer #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .prog_wr_en    (prog_wr_en),
        .prog_wr_addr  (prog_wr_addr),
        .prog_wr_data  (prog_wr_data),
        .prog_len      (prog_len),
        .loop_cnt      (loop_cnt),
        .start         (start),
        .abort         (abort),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .halt          (halt),
        .busy          (busy),
        .pass_idx      (pass_idx),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int addr, input logic [INSTR_W-1:0] data);
        @(negedge clk);
        prog_wr_en   = 1'b1;
        prog_wr_addr = AW'(addr);
        prog_wr_data = data;
        @(negedge clk);
        prog_wr_en   = 1'b0;
        model[addr]  = data;
    endtask

    task automatic wait_idle(input string nm);
        start = 1'b0;
        for (int i = 0; i < 5 && busy; i++) @(negedge clk);
        chk({nm, " idle_busy"}, busy, 0);
        chk({nm, " idle_halt"}, halt, 1);
    endtask

    // Runs one program; abort_at>0 aborts after that many handshakes.
    task automatic run(input string nm, input int len, input int loops, input int nexp,
                       input bit toggle, input int abort_at, input int exp_pass);
        int got, cyc, stop;
        bit stalled;
        logic [INSTR_W-1:0] held;
        got = 0; cyc = 0; stalled = 1'b0; held = '0;
        stop = (abort_at > 0) ? abort_at : nexp;
        @(negedge clk);
        prog_len = (AW+1)'(len);
        loop_cnt = 16'(loops);
        start = 1'b1;
        m_axis_tready = 1'b1;
        while (got < stop && cyc < 400) begin
            @(negedge clk);
            cyc++;
            m_axis_tready = toggle ? rdy_pat[(cyc-1) % 4] : 1'b1;
            if (cyc == 2) begin
                chk({nm, " prime_tvalid"}, m_axis_tvalid, 0);
                chk({nm, " prime_halt"}, halt, 0);
                chk({nm, " prime_busy"}, busy, 1);
                chk({nm, " err_cleared"}, err, 0);
            end
            if (cyc == 3) chk({nm, " first_valid_cycle3"}, m_axis_tvalid, 1);
            if (stalled) begin
                chk({nm, " stall_tvalid"}, m_axis_tvalid, 1);
                chk({nm, " stall_tdata"}, m_axis_tdata, held);
            end
            stalled = 1'b0;
            if (m_axis_tvalid) begin
                if (m_axis_tready) begin
                    chk({nm, " word"}, m_axis_tdata, model[got % len]);
                    got++;
                end else begin
                    stalled = 1'b1;
                    held = m_axis_tdata;
                end
            end else if (got > 0 && !toggle) begin
                chk({nm, " bubble"}, m_axis_tvalid, 1);
            end
        end
        chk({nm, " count"}, got, stop);
        if (abort_at > 0) begin
            @(negedge clk);
            abort = 1'b1;
            m_axis_tready = 1'b0;
        end
        @(negedge clk);
        abort = 1'b0;
        chk({nm, " done_tvalid"}, m_axis_tvalid, 0);
        chk({nm, " done_halt"}, halt, 1);
        chk({nm, " done_busy"}, busy, 1);
        chk({nm, " pass_idx"}, pass_idx, exp_pass);
        @(negedge clk);
        chk({nm, " done_hold_busy"}, busy, 1);
        wait_idle(nm);
    endtask

    initial begin
        rst = 1'b0;
        prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
        prog_len = '0; loop_cnt = 16'd0; start = 1'b0; abort = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_halt", halt, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass_idx, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) load(i, INSTR_W'(i + 1));
        run("basic", 5, 1, 5, 1'b0, 0, 0);
        run("toggle", 5, 1, 5, 1'b1, 0, 0);
        run("abort", 5, 1, 5, 1'b0, 2, 0);

        // Write while busy must be dropped and flag err.
        @(negedge clk);
        prog_len = 11'd5; loop_cnt = 16'd1; start = 1'b1; m_axis_tready = 1'b0;
        repeat (4) @(negedge clk);
        chk("wr_busy_busy", busy, 1);
        prog_wr_en = 1'b1; prog_wr_addr = '0; prog_wr_data = 17'h1FFFF;
        @(negedge clk);
        prog_wr_en = 1'b0;
        chk("wr_busy_err", err, 1);
        chk("wr_busy_hold_tdata", m_axis_tdata, 17'h00001);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("wr_busy_abort_tvalid", m_axis_tvalid, 0);
        chk("wr_busy_abort_halt", halt, 1);
        wait_idle("wr_busy");
        run("ram_kept", 5, 1, 5, 1'b0, 0, 0);

        // Illegal length zero.
        @(negedge clk);
        prog_len = 11'd0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("len0_err", err, 1);
            chk("len0_busy", busy, 0);
            chk("len0_tvalid", m_axis_tvalid, 0);
            chk("len0_halt", halt, 1);
        end
        start = 1'b0;

        load(0, 17'h0000A); load(1, 17'h0000B); load(2, 17'h0000C);
`ifdef SEQ_LOOP_EN
        run("loop", 3, 4, 12, 1'b0, 0, 3);
        run("toggle_loop", 3, 2, 6, 1'b1, 0, 1);
`else
        run("loop", 3, 4, 3, 1'b0, 0, 0);
        run("toggle_loop", 3, 2, 3, 1'b1, 0, 0);
`endif
        run("len1_loop0", 1, 0, 1, 1'b0, 0, 0);

        // Illegal length DEPTH+1.
        @(negedge clk);
        prog_len = 11'd1025; start = 1'b1;
        repeat (2) @(negedge clk);
        chk("len1025_err", err, 1);
        chk("len1025_busy", busy, 0);
        start = 1'b0;

        // Asynchronous reset mid-stream.
        @(negedge clk);
        prog_len = 11'd3; loop_cnt = 16'd1; start = 1'b1; m_axis_tready = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_tvalid_before_rst", m_axis_tvalid, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_halt", halt, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tdata", m_axis_tdata, 0);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
